// File: rtl/cpu_defs.sv
// Shared definitions for the multicycle MIPS datapath: well-known register
// indices, the stack-pointer reset value and the register-destination mux codes.
// The control unit, the destination mux and the register bank all import this
// package so that these values are defined in a single place.
package cpu_defs;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    // Architecturally special register indices.
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

    // Initial stack pointer loaded into $29 on reset.
    localparam int unsigned SP_INIT = 227;

    // Register-destination mux select codes (write_reg source).
    typedef enum logic [2:0] {
        RD_RT = 3'b000,   // I-type destination: inst[20:16]
        RD_RD = 3'b001,   // R-type destination: inst[15:11]
        RD_SP = 3'b010,   // implicit stack-pointer update
        RD_RA = 3'b011,   // jal link register
        RD_RS = 3'b100    // destination taken from inst[25:21]
    } rd_sel_e;

endpackage

// File: rtl/reg_cell.sv
// One general-purpose register: DATA_W bits, synchronous reset to RST_VAL and a
// load enable. Reset wins over load so a write in the reset cycle is dropped.
module reg_cell #(
    parameter int unsigned          DATA_W  = 32,
    parameter logic [DATA_W-1:0]    RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Register state: reset value first, otherwise load new data when enabled.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples its
    // inputs from before the edge, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// 32 x 32-bit register file of the multicycle MIPS datapath. Two combinational
// read ports feed the A/B operand latches; one synchronous write port is loaded
// from the write-back mux. $0 is hardwired to zero and has no storage; $29
// resets to the initial stack pointer, every other register resets to zero.
// Reads see stored contents only: a value written at an edge appears on the
// read ports after that edge (no write-to-read bypass).
module reg_bank
    import cpu_defs::*;
#(
    parameter int unsigned DATA_W  = cpu_defs::DATA_W,
    parameter int unsigned ADDR_W  = cpu_defs::ADDR_W,
    parameter int unsigned SP_INIT = cpu_defs::SP_INIT,
    parameter int unsigned SP_IDX  = 29
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    // Stored register contents; entry 0 is a constant, not a flop.
    logic [DATA_W-1:0] regs [NUM_REGS];

    // Per-register load enables; there is no enable for $0.
    logic [NUM_REGS-1:1] write_en;

    // Write-enable decoder: one-hot select of the destination register.
    // NOTE: write_en is fully assigned before the loop so no latch is inferred
    // when reg_write is low or the index matches nothing.
    always_comb begin
        write_en = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            write_en[i] = reg_write && (write_reg == ADDR_W'(i));
        end
    end

    // $0 reads as zero forever; writes to it are discarded by the decoder.
    assign regs[0] = '0;

    // Registers 1..NUM_REGS-1; only the stack pointer has a non-zero reset value.
    // NOTE: every storage cell is reset, so no register can read X once the
    // first reset edge has been seen.
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs
        localparam logic [DATA_W-1:0] RST_VAL =
            (g == SP_IDX) ? DATA_W'(SP_INIT) : '0;

        reg_cell #(
            .DATA_W  (DATA_W),
            .RST_VAL (RST_VAL)
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .load  (write_en[g]),
            .d     (write_data),
            .q     (regs[g])
        );
    end

    // Two independent 32:1 read muxes from stored contents (zero latency).
    always_comb begin
        read_data1 = regs[read_reg1];
        read_data2 = regs[read_reg2];
    end

endmodule
